// File: rtl/q5_pkg.sv
// Shared types and widths for the Q5 event-capture slice.
package q5_pkg;

    localparam int Q_W     = 4;
    localparam int SEQ_W   = 4;
    localparam int ENTRY_W = Q_W + SEQ_W;

    // Bit positions of each field inside a packed entry.
    localparam int ENTRY_Q_LSB   = 0;
    localparam int ENTRY_SEQ_LSB = Q_W;

    // One captured event: sequence tag in the upper nibble, count value below.
    typedef struct packed {
        logic [SEQ_W-1:0] seq;
        logic [Q_W-1:0]   q;
    } entry_t;

    // Build an entry from its two fields.
    function automatic entry_t make_entry(input logic [SEQ_W-1:0] seq, input logic [Q_W-1:0] q);
        entry_t e;
        e.seq = seq;
        e.q   = q;
        return e;
    endfunction

endpackage

// File: rtl/evt_fifo.sv
// First-word-fall-through FIFO with extra-MSB pointers.
// A push while full is accepted only if a pop happens in the same cycle.
module evt_fifo #(
    parameter int DEPTH   = 4,
    parameter int ENTRY_W = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               push,
    input  logic [ENTRY_W-1:0] din,
    input  logic               pop,
    output logic [ENTRY_W-1:0] dout,
    output logic               empty,
    output logic               full
);

    localparam int AW    = $clog2(DEPTH);
    localparam int PTR_W = AW + 1;

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic               pop_ok;
    logic               push_ok;

    // Pointer comparison: equal means empty, differing only in the MSB means full.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = ((wr_ptr ^ rd_ptr) == {1'b1, {AW{1'b0}}});
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);

    // Head entry falls through; forced to zero while empty so stale storage never shows.
    assign dout = empty ? '0 : mem[rd_ptr[AW-1:0]];

    // Pointer register: advance on accepted push/pop.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
        end
    end

    // Storage write.
    // NOTE: the array has no reset; its contents are unobservable while the pointers say empty.
    always_ff @(posedge clock) begin
        if (push_ok) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/upper_event_capture.sv
// Captures the count value at each rising edge of upper into a tagged FIFO,
// and keeps a saturating event total plus a sticky drop flag.
module upper_event_capture
    import q5_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [Q_W-1:0]     q,
    input  logic               upper,
    input  logic               rd_en,
    input  logic               clr_ovf,
    output logic [ENTRY_W-1:0] rd_data,
    output logic               rd_valid,
    output logic               full,
    output logic               overflow,
    output logic [CNT_W-1:0]   event_count
);

    logic             upper_d;
    logic             evt;
    logic             empty;
    logic             pop;
    logic             drop;
    logic [SEQ_W-1:0] seq;
    entry_t           din;

    assign evt      = upper & ~upper_d;
    assign rd_valid = ~empty;
    assign pop      = rd_en & rd_valid;
    // An event is lost only when the FIFO is full and no slot frees this cycle.
    assign drop     = evt & full & ~pop;

    // Entry assembly from the live count value and current sequence tag.
    // NOTE: every combinational output is assigned unconditionally first, so no latch can form.
    always_comb begin
        din = make_entry(seq, q);
    end

    // Edge detector, sequence tag and saturating total.
    // upper_d resets high so upper already high at reset release is not an edge.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            upper_d     <= 1'b1;
            seq         <= '0;
            event_count <= '0;
        end else begin
            upper_d <= upper;
            if (evt) begin
                seq <= seq + SEQ_W'(1);
                if (event_count != {CNT_W{1'b1}}) event_count <= event_count + CNT_W'(1);
            end
        end
    end

    // Sticky overflow: a drop sets it and wins over a simultaneous clear.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)       overflow <= 1'b0;
        else if (drop)    overflow <= 1'b1;
        else if (clr_ovf) overflow <= 1'b0;
    end

    evt_fifo #(
        .DEPTH   (DEPTH),
        .ENTRY_W (ENTRY_W)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (evt),
        .din   (din),
        .pop   (rd_en),
        .dout  (rd_data),
        .empty (empty),
        .full  (full)
    );

endmodule

// File: tb/tb_upper_event_capture.sv
// Bench for upper_event_capture: directed stimulus pushes hand-computed entries
// into a scoreboard queue; a negedge monitor checks every popped head entry.
module tb_upper_event_capture;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] q = 4'h0;
    logic       upper = 1'b1;
    logic       rd_en = 1'b0;
    logic       clr_ovf = 1'b0;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       full;
    logic       overflow;
    logic [7:0] event_count;

    int         n_checks = 0;
    int         n_fail = 0;
    logic [7:0] exp_q [$];

    upper_event_capture #(.DEPTH(4), .CNT_W(8)) dut (
        .clock       (clock),
        .reset       (reset),
        .q           (q),
        .upper       (upper),
        .rd_en       (rd_en),
        .clr_ovf     (clr_ovf),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .full        (full),
        .overflow    (overflow),
        .event_count (event_count)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, got, want);
        end
    endtask

    // Monitor: a pop is committed at the next posedge whenever rd_en & rd_valid now.
    always @(negedge clock) begin
        if (reset && rd_valid && rd_en) begin
            if (exp_q.size() == 0) begin
                check("unexpected_pop", {24'h0, rd_data}, 32'hFFFF_FFFF);
            end else begin
                check("rd_data", {24'h0, rd_data}, {24'h0, exp_q.pop_front()});
            end
        end
    end

    task automatic do_reset();
        @(posedge clock); #1;
        reset = 1'b0; upper = 1'b0; rd_en = 1'b0; clr_ovf = 1'b0;
        exp_q.delete();
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;
    endtask

    // One rising edge of upper with count qv; kept entries go to the scoreboard.
    task automatic ev(input logic [3:0] qv, input bit kept, input logic [7:0] want);
        @(posedge clock); #1;
        upper = 1'b1; q = qv;
        if (kept) exp_q.push_back(want);
        @(posedge clock); #1;
        upper = 1'b0;
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock); #1;
            rd_en = 1'b1;
        end
        @(posedge clock); #1;
        rd_en = 1'b0;
    endtask

    initial begin
        // Reset release with upper already high: no event.
        repeat (3) @(posedge clock);
        #1 reset = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rr_event_count", {24'h0, event_count}, 32'h0);
        check("rr_rd_valid", {31'h0, rd_valid}, 32'h0);
        check("rr_rd_data", {24'h0, rd_data}, 32'h0);
        check("rr_overflow", {31'h0, overflow}, 32'h0);
        #1 upper = 1'b0;

        // Single capture.
        ev(4'h8, 1'b1, 8'h08);
        @(negedge clock);
        check("single_rd_valid", {31'h0, rd_valid}, 32'h1);
        check("single_rd_data", {24'h0, rd_data}, 32'h08);
        check("single_count", {24'h0, event_count}, 32'h1);
        drain(1);
        @(negedge clock);
        check("single_empty_after_pop", {31'h0, rd_valid}, 32'h0);

        // Overflow: five edges, no reads.
        do_reset();
        ev(4'h9, 1'b1, 8'h09);
        ev(4'hA, 1'b1, 8'h1A);
        ev(4'hB, 1'b1, 8'h2B);
        @(negedge clock);
        check("ovf_not_full_3", {31'h0, full}, 32'h0);
        ev(4'hC, 1'b1, 8'h3C);
        @(negedge clock);
        check("ovf_full_4", {31'h0, full}, 32'h1);
        check("ovf_clear_4", {31'h0, overflow}, 32'h0);
        ev(4'hD, 1'b0, 8'h4D);
        @(negedge clock);
        check("ovf_set_5", {31'h0, overflow}, 32'h1);
        check("ovf_count_5", {24'h0, event_count}, 32'h5);
        drain(4);
        @(negedge clock);
        check("ovf_drained", {31'h0, rd_valid}, 32'h0);

        // Full with simultaneous push and pop.
        do_reset();
        ev(4'h1, 1'b1, 8'h01);
        ev(4'h2, 1'b1, 8'h12);
        ev(4'h3, 1'b1, 8'h23);
        ev(4'h4, 1'b1, 8'h34);
        @(posedge clock); #1;
        upper = 1'b1; q = 4'hE; rd_en = 1'b1;
        exp_q.push_back(8'h4E);
        @(posedge clock); #1;
        upper = 1'b0; rd_en = 1'b0;
        @(negedge clock);
        check("pp_full", {31'h0, full}, 32'h1);
        check("pp_no_overflow", {31'h0, overflow}, 32'h0);
        drain(4);
        @(negedge clock);
        check("pp_drained", {31'h0, rd_valid}, 32'h0);

        // clr_ovf coinciding with a drop: set wins.
        ev(4'h5, 1'b1, 8'h55);
        ev(4'h6, 1'b1, 8'h66);
        ev(4'h7, 1'b1, 8'h77);
        ev(4'h8, 1'b1, 8'h88);
        ev(4'h9, 1'b0, 8'h99);
        @(negedge clock);
        check("clr_ovf_set", {31'h0, overflow}, 32'h1);
        @(posedge clock); #1;
        upper = 1'b1; q = 4'hA; clr_ovf = 1'b1;
        @(posedge clock); #1;
        upper = 1'b0; clr_ovf = 1'b0;
        @(negedge clock);
        check("clr_vs_drop", {31'h0, overflow}, 32'h1);
        @(posedge clock); #1 clr_ovf = 1'b1;
        @(posedge clock); #1 clr_ovf = 1'b0;
        @(negedge clock);
        check("clr_alone", {31'h0, overflow}, 32'h0);
        check("clr_count", {24'h0, event_count}, 32'd11);
        drain(4);

        // Saturation and seq wrap with continuous reads.
        do_reset();
        @(posedge clock); #1 rd_en = 1'b1;
        for (int i = 0; i < 300; i++) begin
            logic [7:0] iv;
            logic [3:0] qv;
            iv = 8'(i);
            qv = 4'hF - iv[3:0];
            ev(qv, 1'b1, {iv[3:0], qv});
            if (i == 254) begin
                @(negedge clock);
                check("sat_count_255", {24'h0, event_count}, 32'd255);
            end
        end
        @(negedge clock);
        check("sat_count_hold", {24'h0, event_count}, 32'd255);
        check("sat_no_overflow", {31'h0, overflow}, 32'h0);
        @(posedge clock); #1 rd_en = 1'b0;
        repeat (2) @(posedge clock);

        // Mid-stream asynchronous reset.
        ev(4'h7, 1'b0, 8'h00);
        @(negedge clock);
        check("mid_pre_valid", {31'h0, rd_valid}, 32'h1);
        #2 reset = 1'b0;
        exp_q.delete();
        #1;
        check("mid_rd_valid", {31'h0, rd_valid}, 32'h0);
        check("mid_rd_data", {24'h0, rd_data}, 32'h0);
        check("mid_count", {24'h0, event_count}, 32'h0);
        check("mid_full", {31'h0, full}, 32'h0);
        check("mid_overflow", {31'h0, overflow}, 32'h0);
        @(posedge clock); #1 reset = 1'b1;

        check("scoreboard_empty", exp_q.size(), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/upper_event_capture.md
Name: upper_event_capture

Overview:
- Downstream consumer of the Q5 counter outputs (4-bit count Q, flag upper).
- Detects each rising edge of upper and records the count value at that edge, tagged with a 4-bit event sequence number, in a small first-word-fall-through FIFO.
- Also keeps a saturating total event count and a sticky overflow flag.
- Drained by a host-side reader through an rd_en/rd_valid handshake.

Parameters:
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- CNT_W, 8, width of the saturating event counter.

Ports:
- clock  input  1  system clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-low reset.
- q  input  4  count value from the upstream counter (Q5.Q).
- upper  input  1  flag from the upstream counter (Q5.upper).
- rd_en  input  1  pop request; honoured only when rd_valid=1.
- clr_ovf  input  1  synchronous clear of the overflow flag.
- rd_data  output  8  head entry {seq[3:0], q[3:0]}; valid only when rd_valid=1.
- rd_valid  output  1  FIFO not empty.
- full  output  1  FIFO holds DEPTH entries.
- overflow  output  1  sticky: an event was dropped because the FIFO was full.
- event_count  output  CNT_W  total rising edges detected, saturating at all-ones.

Behaviour:
- Clocking/reset: one clock; reset is asynchronous and active-low.
- Reset values (reset=0):
  - FIFO empty: rd_valid=0, full=0.
  - rd_data=0, overflow=0, event_count=0.
  - seq=0.
  - upper_d=1, so a high upper at reset release does not produce a spurious event.
- Edge detect:
  - upper_d registers upper every cycle.
  - evt = upper & ~upper_d, combinational in the cycle upper is first sampled high.
- On an edge where evt=1:
  - push {seq, q} (q sampled in that same cycle);
  - seq <= seq+1, wrapping 15->0. seq advances even when the push is dropped, so gaps reveal losses.
  - event_count <= event_count+1, holding at 2^CNT_W-1 once reached.
- Push latency: an event captured at edge N gives rd_valid=1 and rd_data equal to the entry after edge N (one-cycle latency).
- FIFO read interface:
  - First-word-fall-through: rd_data always shows the head entry, driven combinationally from the storage array and read pointer.
  - Pop occurs when rd_en & rd_valid at the clock edge. rd_en while empty is ignored with no state change.
- FIFO pointers:
  - Read and write pointers have log2(DEPTH)+1 bits and wrap naturally.
  - full when the pointers differ only in the MSB; empty when they are equal.
- Full boundary:
  - Push with pop in the same cycle while full: both happen, occupancy stays DEPTH, no overflow.
  - Push while full without pop: entry dropped, overflow <= 1.
- Empty boundary: push and rd_en in the same cycle while empty: push happens, pop ignored, occupancy becomes 1.
- Overflow clear: clr_ovf=1 clears overflow next cycle. If a drop occurs in the same cycle, set wins and overflow stays 1.
- Reset mid-operation: all state returns to reset values immediately (asynchronous), and FIFO contents are discarded. Storage contents need not be cleared; they are unobservable while empty.
- No other state machine: the block is pointer/counter driven.

Decomposition:
- Shared package (q5_pkg):
  - Q_W=4, SEQ_W=4, ENTRY_W=Q_W+SEQ_W;
  - entry struct/typedef {seq, q} with field-extraction constants.
- One sub-module: evt_fifo.
  - Parameters: DEPTH, ENTRY_W.
  - Ports: push, din, pop, dout, empty, full.
- The top level holds the edge detector, the seq counter, the saturating counter and the overflow flag.

Test Plan:
- Reset-release check: hold reset=0 with upper=1, then release. Required: no event, event_count=0, rd_valid=0.
- Single capture: upper 0->1 with q=4'h8. Required next cycle: rd_valid=1, rd_data=8'h08, event_count=1. Pop with rd_en=1; rd_valid=0 the cycle after.
- Overflow: 5 rising edges with q=9,A,B,C,D and no reads.
  - Required: full=1 after the 4th edge; overflow=1 after the 5th.
  - Entries read back: 8'h09, 8'h1A, 8'h2B, 8'h3C; the 5th (seq 4) is absent; event_count=5.
- Full with push+pop: FIFO full, rd_en=1 coinciding with a new edge at q=4'hE.
  - Required: no overflow, full stays 1.
  - Last entry out is {seq,4'hE}.
- clr_ovf versus drop: FIFO full, overflow=1; assert clr_ovf in the same cycle as another dropped edge. Required: overflow stays 1. Then clr_ovf alone gives overflow=0 next cycle.
- Saturation and wrap: 300 edges with continuous reads (CNT_W=8).
  - Required: event_count=255 and holds there.
  - seq wraps 15->0 in rd_data.
  - Asserting reset mid-stream clears all outputs immediately.
